// File: rtl/score_display_if.sv
// Bus between the score logic and the seven-segment driver.
//
// Handshake: in_LOAD is the request (valid) and !out_BUSY is ready. A value
// transfers on a rising clock edge where in_LOAD=1 and out_BUSY=0; a request
// seen while out_BUSY=1 is dropped, not queued, and the caller re-issues it.
// out_SEG/out_OVF change only on the edge where out_BUSY falls.
interface score_display_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic [BIN_W-1:0]    in_VALUE;
  logic                in_LOAD;
  logic [7*DIGITS-1:0] out_SEG;
  logic                out_BUSY;
  logic                out_OVF;
  logic [1:0]          dbg_state;

  modport master (
    output in_VALUE, in_LOAD,
    input  out_SEG, out_BUSY, out_OVF, dbg_state
  );

  modport slave (
    input  in_VALUE, in_LOAD,
    output out_SEG, out_BUSY, out_OVF, dbg_state
  );
endinterface

// File: rtl/score_display.sv
// Multi-digit active-low seven-segment driver for the scoreboard.
// Decimal mode converts with a sequential double-dabble (one bit per cycle);
// hex mode shows the captured nibbles directly. Supports leading-zero
// blanking and shows dashes when the value does not fit.
module score_display #(
  parameter int DIGITS   = 2,
  parameter int BIN_W    = 7,
  parameter int HEX_MODE = 0,
  parameter int BLANK_LZ = 1
) (
  input logic             in_CLK,
  input logic             in_RESET_N,
  score_display_if.slave  bus
);

  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0011000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [NW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_pend_q;
  logic                ovf_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic                busy_q;
  logic                ovf_q;
  logic [63:0]         val_ext;
  logic [NW-1:0]       nib_src;
  logic [3:0]          nib;
  logic                lead;

  // Overflow of the incoming value, evaluated at the moment a load is accepted.
  always_comb begin
    val_ext = 64'(bus.in_VALUE);
    ovf_d   = (HEX_MODE != 0) ? ((val_ext >> NW) != 64'd0)
                              : (val_ext >= DEC_LIMIT);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d   = {bcd_adj[NW-2:0], shift_q[BIN_W-1]};
    shift_d = shift_q << 1;
  end

  // Segment pattern for the finished value; scans from the top digit so that
  // "this digit and all above are zero" is a single running flag.
  always_comb begin
    nib_src = (HEX_MODE != 0) ? NW'(shift_q) : bcd_q;
    seg_d   = '1;
    lead    = 1'b1;
    nib     = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = nib_src[4*i +: 4];
      if (ovf_pend_q) begin
        seg_d[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && (i > 0) && lead && (nib == 4'd0)) begin
        seg_d[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_d[7*i +: 7] = seg_code(nib);
        lead = 1'b0;
      end
    end
  end

  // Control FSM with all outputs registered; display changes only in UPDATE.
  always_ff @(posedge in_CLK or negedge in_RESET_N) begin
    if (!in_RESET_N) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      seg_q      <= '1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_LOAD) begin
            shift_q    <= bus.in_VALUE;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_d;
            busy_q     <= 1'b1;
            state_q    <= (HEX_MODE != 0) ? S_UPDATE : S_CONVERT;
          end
        end
        S_CONVERT: begin
          bcd_q      <= bcd_d;
          shift_q    <= shift_d;
          // A carry out of the top digit can only happen when the value is
          // already out of range; folding it in keeps the flag self-consistent.
          ovf_pend_q <= ovf_pend_q | bcd_adj[NW-1];
          if (cnt_q == CNT_LAST) state_q <= S_UPDATE;
          else cnt_q <= cnt_q + CW'(1);
        end
        S_UPDATE: begin
          seg_q   <= seg_d;
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_SEG   = seg_q;
  assign bus.out_BUSY  = busy_q;
  assign bus.out_OVF   = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: four configurations (decimal blank/no-blank,
// hex 2-digit, hex 1-digit) each checked every cycle against a timeline
// model computed from plain arithmetic, plus hand-computed literal checks.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load [4];
  logic [31:0] val  [4];
  logic [55:0] seg_w [4];
  logic        busy_w [4];
  logic        ovf_w [4];
  int          n_cmp = 0;
  int          n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0011000;
      10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;
      14: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Display for value v: digit i = (v / base^i) % base; blank when v < base^i.
  function automatic logic [55:0] model_seg(input int unsigned v, input int d,
                                            input bit hex, input bit bl, output bit ovf);
    logic [55:0]     r;
    longint unsigned base, lim, pw;
    base = hex ? 64'd16 : 64'd10;
    lim  = 1;
    for (int i = 0; i < d; i++) lim = lim * base;
    ovf = (64'(v) >= lim);
    r   = '1;
    pw  = 1;
    for (int i = 0; i < d; i++) begin
      if (ovf) r[7*i +: 7] = 7'b0111111;
      else if (bl && i > 0 && 64'(v) < pw) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = seg_of(32'((64'(v) / pw) % base));
      pw = pw * base;
    end
    return r;
  endfunction

  // ---------------- DUTs, models, per-cycle compare ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D  = (g == 3) ? 1 : 2;
    localparam int W  = (g >= 2) ? 8 : 7;
    localparam int HX = (g >= 2) ? 1 : 0;
    localparam int BL = (g == 1) ? 0 : 1;
    localparam logic [55:0] SM = (56'd1 << (7 * D)) - 56'd1;

    score_display_if #(.DIGITS(D), .BIN_W(W)) bus ();

    score_display #(.DIGITS(D), .BIN_W(W), .HEX_MODE(HX), .BLANK_LZ(BL)) u_dut (
      .in_CLK     (clk),
      .in_RESET_N (rst_n),
      .bus        (bus)
    );

    assign bus.in_VALUE = val[g][W-1:0];
    assign bus.in_LOAD  = load[g];
    assign seg_w[g]     = 56'(bus.out_SEG);
    assign busy_w[g]    = bus.out_BUSY;
    assign ovf_w[g]     = bus.out_OVF;

    // Timeline model: accept when free, result appears LAT edges later.
    int          rem = 0;
    logic [55:0] e_seg = '1;
    logic [55:0] p_seg = '1;
    bit          e_busy = 1'b0, e_ovf = 1'b0, p_ovf = 1'b0;
    int unsigned vv;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rem = 0; e_seg = '1; e_busy = 1'b0; e_ovf = 1'b0;
      end else if (rem == 0) begin
        if (load[g]) begin
          vv     = val[g] & ((32'd1 << W) - 32'd1);
          p_seg  = model_seg(vv, D, HX != 0, BL != 0, p_ovf);
          rem    = (HX != 0) ? 1 : W + 1;
          e_busy = 1'b1;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          e_seg = p_seg; e_ovf = p_ovf; e_busy = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("dut%0d_seg", g), seg_w[g], e_seg & SM);
      chk($sformatf("dut%0d_busy", g), 64'(busy_w[g]), 64'(e_busy));
      chk($sformatf("dut%0d_ovf", g), 64'(ovf_w[g]), 64'(e_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input int idx, input logic [31:0] v);
    val[idx]  = v;
    load[idx] = 1'b1;
    @(posedge clk); #1;
    load[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx, output int cyc);
    cyc = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (busy_w[idx]) cyc++;
      else break;
    end
    chk($sformatf("dut%0d_idle_timeout", idx), 64'(busy_w[idx]), 64'd0);
  endtask

  function automatic logic [31:0] pick(input int idx);
    logic [31:0] corners [9];
    logic [31:0] m;
    corners = '{0, 9, 10, 99, 100, 15, 16, 127, 255};
    m = (idx >= 2) ? 32'hFF : 32'h7F;
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 8)] & m;
    return $urandom() & m;
  endfunction

  // ---------------- stimulus ----------------
  int cyc;
  bit hold;

  initial begin
    for (int i = 0; i < 4; i++) begin load[i] = 1'b0; val[i] = '0; end
    #12;
    chk("reset_seg", seg_w[0], 56'h3FFF);
    chk("reset_busy", 64'(busy_w[0]), 64'd0);
    chk("reset_ovf", 64'(ovf_w[0]), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // decimal 42
    do_load(0, 42);
    wait_idle(0, cyc);
    chk("dec42_seg", seg_w[0], 56'({7'b0011001, 7'b0100100}));
    chk("dec42_busy_cycles", 64'(cyc), 64'd8);
    chk("dec42_ovf", 64'(ovf_w[0]), 64'd0);

    // blanking
    do_load(0, 7);  wait_idle(0, cyc);
    chk("blank7_seg", seg_w[0], 56'({7'b1111111, 7'b1111000}));
    do_load(0, 0);  wait_idle(0, cyc);
    chk("blank0_seg", seg_w[0], 56'({7'b1111111, 7'b1000000}));
    do_load(1, 7);  wait_idle(1, cyc);
    chk("noblank7_seg", seg_w[1], 56'({7'b1000000, 7'b1111000}));

    // overflow then recovery
    do_load(0, 100); wait_idle(0, cyc);
    chk("ovf100_seg", seg_w[0], 56'({7'b0111111, 7'b0111111}));
    chk("ovf100_flag", 64'(ovf_w[0]), 64'd1);
    do_load(0, 99);  wait_idle(0, cyc);
    chk("dec99_seg", seg_w[0], 56'({7'b0011000, 7'b0011000}));
    chk("dec99_flag", 64'(ovf_w[0]), 64'd0);

    // hex
    do_load(2, 32'h2F); wait_idle(2, cyc);
    chk("hex2f_seg", seg_w[2], 56'({7'b0100100, 7'b0001110}));
    chk("hex2f_busy_cycles", 64'(cyc), 64'd1);
    do_load(3, 32'hA0); wait_idle(3, cyc);
    chk("hexA0_seg", seg_w[3], 56'(7'b0111111));
    chk("hexA0_ovf", 64'(ovf_w[3]), 64'd1);

    // load while busy is dropped
    do_load(0, 42);
    repeat (2) @(posedge clk); #1;
    val[0] = 13; load[0] = 1'b1;
    @(posedge clk); #1; load[0] = 1'b0;
    wait_idle(0, cyc);
    chk("busy_ignore_seg", seg_w[0], 56'({7'b0011001, 7'b0100100}));

    // reset in the middle of a conversion
    do_load(0, 99);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("midreset_seg", seg_w[0], 56'h3FFF);
    chk("midreset_busy", 64'(busy_w[0]), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    do_load(0, 5); wait_idle(0, cyc);
    chk("after_reset5_seg", seg_w[0], 56'({7'b1111111, 7'b0010010}));
    chk("after_reset5_cycles", 64'(cyc), 64'd8);
    @(posedge clk); #1;

    // randomized traffic, including held-high load phases and one reset pulse
    hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) hold = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) begin
        load[i] = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
        val[i]  = pick(i);
      end
      if (c == 2000) begin
        #2; rst_n = 1'b0;
        #1; rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) load[i] = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Parametrised multi-digit seven-segment driver for the Pong scoreboard. It converts a binary score into DIGITS active-low seven-segment codes, either as decimal via a sequential double-dabble or as hexadecimal nibbles. It adds optional leading-zero blanking, overflow indication and a busy handshake. It sits between the game-state/score logic and the board's HEX display pins.

## Interface
- DIGITS, 2: number of displayed digits (1..8).
- BIN_W, 7: width of the binary input value (1..27).
- HEX_MODE, 0: 0 = decimal display, 1 = hexadecimal display.
- BLANK_LZ, 1: 1 = blank leading zero digits; digit 0 is always shown.
- in_CLK  input  1  sole clock, rising edge.
- in_RESET_N  input  1  reset, asynchronous assert, active-low.
- in_VALUE  input  BIN_W  binary value, sampled when a load is accepted.
- in_LOAD  input  1  load request, single-cycle or level; accepted only when out_BUSY=0.
- out_SEG  output  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; bits [6:0] hold digit 0 (least significant).
- out_BUSY  output  1  high while a conversion is in progress.
- out_OVF  output  1  value of the last accepted load does not fit in DIGITS digits.

## Operation
- One clock. Reset is asynchronous and active-low, and applies to all registers.
- Reset values:
  - out_SEG all ones (every digit blank, 7'b1111111).
  - out_BUSY=0, out_OVF=0.
  - FSM in IDLE.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE with in_LOAD=1:
  - Capture in_VALUE into the shift register.
  - Clear the BCD register (4*DIGITS bits) and compute the overflow flag.
  - Go to CONVERT if HEX_MODE=0, otherwise to UPDATE.
- Overflow condition:
  - Decimal mode: in_VALUE > 10^DIGITS-1.
  - Hex mode: any bit of in_VALUE above bit 4*DIGITS-1 is set.
- CONVERT runs for exactly BIN_W cycles. Each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {BCD, shift register} left by one.
  - Then go to UPDATE.
- UPDATE registers out_SEG and out_OVF from the BCD register (decimal) or the low 4*DIGITS bits of the captured value (hex), then returns to IDLE.
- Segment codes (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - dash=0111111, blank=1111111
- Overflow display: every digit shows a dash and out_OVF=1. Blanking is not applied.
- Blanking (BLANK_LZ=1): a digit i>0 is blank if it and every digit above it are zero. Digit 0 always shows its code.
- in_LOAD while out_BUSY=1 or in UPDATE is ignored. The request is dropped and not queued; the caller re-issues it.
- out_SEG holds its last value during a conversion and changes only on the UPDATE edge.

## Timing
- Load accepted at rising edge k: out_BUSY=1 from edge k.
- Decimal mode:
  - out_SEG and out_OVF update at edge k+BIN_W+1.
  - out_BUSY falls at the same edge.
  - The earliest next accept is edge k+BIN_W+2.
- Hex mode:
  - out_SEG and out_OVF update at edge k+1.
  - out_BUSY falls at edge k+1.
  - The earliest next accept is edge k+2.
- in_LOAD held high continuously: a new load is accepted on every first IDLE edge, so the display refreshes back-to-back.
- Reset asserted mid-conversion:
  - Immediate return to the reset values: all digits blank, out_BUSY=0.
  - The partial result is discarded.
  - The first load after deassert behaves as from power-up.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Decimal, DIGITS=2, BIN_W=7: load 42 at edge k → out_SEG digit1=0011001, digit0=0100100 at edge k+8; out_BUSY high for 8 cycles; out_OVF=0.
- Blanking, same config, BLANK_LZ=1: load 7 → digit1=1111111, digit0=1111000. Load 0 → digit1 blank, digit0=1000000. With BLANK_LZ=0, loading 7 gives digit1=1000000.
- Overflow, same config: load 100 → both digits 0111111, out_OVF=1. A following load of 99 → 0011000/0011000, out_OVF=0.
- Hex, HEX_MODE=1, BIN_W=8, DIGITS=2: load 0x2F → digit1=0100100, digit0=0001110 one edge after accept. Load 0xA0 with DIGITS=1 → dash, out_OVF=1.
- Load while busy: load 42, then pulse in_LOAD with 13 at edge k+3 → the second load is ignored and the display shows 42.
- Reset mid-conversion: load 99, assert in_RESET_N low at k+4 asynchronously → out_SEG immediately all ones, out_BUSY=0. After release, load 5 → digit0=0010010 after BIN_W+1 edges.
